vending_ctrl_multi: RTL and testbench
=====================================

VENDING_CTRL_MULTI -- requirements
Module: vending_ctrl_multi

Interface
REQ-001 Parameter N_PROD, 4: number of selectable products, 2..16.
REQ-002 Parameter CREDIT_W, 8: credit and change width in coin units.
REQ-003 Parameter COIN_W, 4: coin value width.
REQ-004 Parameter PRICES, {7,9,2,4} packed N_PROD x CREDIT_W: price per product index; PRICES[0] is the LSB slice.
REQ-005 Parameter MOTOR_CYC, 50: motor-on duration in clock cycles, >=1.
REQ-006 Parameter TIMEOUT_CYC, 1000: inactivity cycles in COINS before auto-refund, >=2.
REQ-007 Parameter STOCK_INIT, 3: initial units per product (used only with VEND_STOCK_EN).
REQ-008 clk  in  1  single clock; all state changes on its rising edge.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 start_p, coin_p, buy_p, cancel_p  in  1 each  single-cycle, active-high, already debounced/edge-detected strobes.
REQ-011 coin_val  in  COIN_W  value of the inserted coin; sampled with coin_p.
REQ-012 sel  in  clog2(N_PROD)  product index; sampled only with buy_p.
REQ-013 collected  in  1  level; product removed by customer.
REQ-014 credit, change  out  CREDIT_W  registered current credit and pending change.
REQ-015 motor  out  1  registered dispense motor drive.
REQ-016 state  out  2  encoded FSM state: IDLE=0, COINS=1, DISPENSE=2, COLLECT=3.
REQ-017 err_insuf, err_soldout, coin_rej  out  1 each  registered single-cycle error pulses.

Function
REQ-018 IDLE: start_p -> COINS, change cleared to 0, credit cleared to 0; all other strobes ignored.
REQ-019 COINS: coin_p -> credit += coin_val on the next edge, unless the sum exceeds 2^CREDIT_W-1, in which case credit is unchanged and coin_rej pulses.
REQ-020 COINS priority for same-cycle strobes: cancel_p > buy_p > coin_p; the lower-priority strobes are discarded.
REQ-021 COINS cancel_p -> change = credit, credit = 0, -> IDLE.
REQ-022 COINS buy_p with credit >= PRICES[sel] (and stock > 0 when enabled) -> change = credit - PRICES[sel], credit = 0, motor = 1, -> DISPENSE.
REQ-023 COINS buy_p with credit < PRICES[sel] -> err_insuf pulse, stay in COINS, credit unchanged.
REQ-024 sel >= N_PROD at buy_p is treated as insufficient credit (err_insuf).
REQ-025 Inactivity counter reloads on entering COINS and on every accepted coin/buy/cancel; at TIMEOUT_CYC cycles -> behaves as cancel.
REQ-026 DISPENSE: motor high for exactly MOTOR_CYC cycles, then motor = 0 and -> COLLECT; all strobes ignored.
REQ-027 COLLECT: collected = 1 -> IDLE on the next edge; change is held until the next start_p.
REQ-028 collected is ignored in every state except COLLECT.
REQ-029 Error pulses last exactly one cycle and never assert in the same cycle as a state change.

Reset
REQ-030 rst low, asynchronously: state = IDLE, credit = 0, change = 0, motor = 0, all pulses 0, timers 0, stock = STOCK_INIT.
REQ-031 Reset asserted mid-DISPENSE drops motor immediately without waiting for a clock edge.

Configuration
REQ-032 Macro VEND_STOCK_EN defined: per-product stock counters, decremented on entering DISPENSE.
REQ-033 With VEND_STOCK_EN, buy_p on a product with stock 0 -> err_soldout, stay in COINS, credit unchanged; sold-out takes priority over insufficient credit.
REQ-034 Without VEND_STOCK_EN: no stock logic is built and err_soldout is tied to 0.

Structure
REQ-035 Package vending_pkg holds the state encoding constants and the price-slice width helper.
REQ-036 Sub-module vend_timer: loadable down-counter with a done flag, instanced once and shared between the motor duration and the inactivity timeout.

Verification
REQ-037 PRICES[2]=2, sel=2, start, coins 1,1, buy -> motor high 50 cycles, change=0, collected -> IDLE.
REQ-038 sel=3 (price 4), coins 3,3, buy -> change=2, credit=0, DISPENSE; change still 2 in IDLE until start_p.
REQ-039 sel=1 (price 9), coins 2,2, buy -> err_insuf 1 cycle, credit=4, state COINS; no strobe for 1000 cycles -> change=4, IDLE.
REQ-040 Credit 250 (CREDIT_W=8), coin 9 -> coin_rej, credit stays 250; cancel + buy in same cycle -> change=250, IDLE, no motor.
REQ-041 VEND_STOCK_EN, STOCK_INIT=1, buy sel=2 twice -> second buy gives err_soldout, credit retained.
REQ-042 rst low at DISPENSE cycle 10 -> motor 0 asynchronously, credit=0, change=0, state 0.

Source files
------------

// File: rtl/vending_pkg.sv
// ============================================================================
// Module      : vending_pkg
// Description : Shared state encoding and price-slice helpers for the vending
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_pkg;

   localparam int C_STATE_W = 2;

   typedef enum logic [C_STATE_W-1:0] {
      ST_IDLE     = 2'd0,
      ST_COINS    = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_COLLECT  = 2'd3
   } vend_state_t;

   // Total width of the packed price table.
   function automatic int prices_w(input int n_prod, input int width);
      return n_prod * width;
   endfunction

   // LSB position of one product's price slice within the packed table.
   function automatic int price_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vend_timer.sv
// ============================================================================
// Module      : vend_timer
// Description : Loadable down-counter; done is high while one cycle remains.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign done = (r_count == W'(1));

endmodule

`default_nettype wire

// File: rtl/vending_ctrl_multi.sv
// ============================================================================
// Module      : vending_ctrl_multi
// Description : Multi-product vending controller: credit, dispense, change and
//               inactivity refund. Optional stock tracking via VEND_STOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_ctrl_multi
   import vending_pkg::*;
#(
   parameter int N_PROD      = 4,
   parameter int CREDIT_W    = 8,
   parameter int COIN_W      = 4,
   parameter logic [prices_w(N_PROD, CREDIT_W)-1:0] PRICES = {8'd4, 8'd2, 8'd9, 8'd7},
   parameter int MOTOR_CYC   = 50,
   parameter int TIMEOUT_CYC = 1000,
   parameter int STOCK_INIT  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_p,
   input  logic                      coin_p,
   input  logic                      buy_p,
   input  logic                      cancel_p,
   input  logic [COIN_W-1:0]         coin_val,
   input  logic [$clog2(N_PROD)-1:0] sel,
   input  logic                      collected,
   output logic [CREDIT_W-1:0]       credit,
   output logic [CREDIT_W-1:0]       change,
   output logic                      motor,
   output logic [C_STATE_W-1:0]      state,
   output logic                      err_insuf,
   output logic                      err_soldout,
   output logic                      coin_rej
);

   localparam int SEL_W   = $clog2(N_PROD);
   localparam int SUM_W   = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;
   localparam int TMR_MAX = (MOTOR_CYC > TIMEOUT_CYC) ? MOTOR_CYC : TIMEOUT_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   vend_state_t         r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] r_change;
   logic                r_motor;
   logic                r_err_insuf;
   logic                r_err_soldout;
   logic                r_coin_rej;

   logic [CREDIT_W-1:0] w_price;
   logic                w_sel_ok;
   logic [SUM_W-1:0]    w_sum;
   logic                w_coin_fit;
   logic                w_soldout;
   logic                w_buy_ok;
   logic                w_in_coins;
   logic                w_activity;
   logic                w_timeout;
   logic                w_tmr_load;
   logic [TMR_W-1:0]    w_tmr_val;
   logic                w_tmr_done;

   always_comb begin
      w_price  = '0;
      w_sel_ok = 1'b0;
      for (int i = 0; i < N_PROD; i++) begin
         if (sel == SEL_W'(i)) begin
            w_price  = PRICES[price_lsb(i, CREDIT_W) +: CREDIT_W];
            w_sel_ok = 1'b1;
         end
      end
   end

   assign w_sum      = SUM_W'(r_credit) + SUM_W'(coin_val);
   assign w_coin_fit = (w_sum[SUM_W-1:CREDIT_W] == '0);

`ifdef VEND_STOCK_EN
   localparam int STK_W = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);

   logic [STK_W-1:0] r_stock [N_PROD];
   logic             w_stock_zero;

   always_comb begin
      w_stock_zero = 1'b0;
      for (int i = 0; i < N_PROD; i++) begin
         if (sel == SEL_W'(i)) begin
            w_stock_zero = (r_stock[i] == '0);
         end
      end
   end

   assign w_soldout = w_sel_ok && w_stock_zero;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_PROD; i++) begin
            r_stock[i] <= STK_W'(STOCK_INIT);
         end
      end else if (w_in_coins && !cancel_p && w_buy_ok) begin
         for (int i = 0; i < N_PROD; i++) begin
            if (sel == SEL_W'(i)) begin
               r_stock[i] <= r_stock[i] - 1'b1;
            end
         end
      end
   end
`else
   assign w_soldout = 1'b0;
`endif

   assign w_buy_ok   = buy_p && w_sel_ok && !w_soldout && (r_credit >= w_price);
   assign w_in_coins = (r_state == ST_COINS);
   // Any strobe seen in COINS restarts the inactivity window; only silence times out.
   assign w_activity = w_in_coins && (cancel_p || buy_p || coin_p);
   assign w_timeout  = w_in_coins && w_tmr_done && !w_activity;

   assign w_tmr_load = ((r_state == ST_IDLE) && start_p) || w_activity;
   assign w_tmr_val  = (w_activity && !cancel_p && w_buy_ok) ? TMR_W'(MOTOR_CYC)
                                                             : TMR_W'(TIMEOUT_CYC);

   vend_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .done     (w_tmr_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_credit      <= '0;
         r_change      <= '0;
         r_motor       <= 1'b0;
         r_err_insuf   <= 1'b0;
         r_err_soldout <= 1'b0;
         r_coin_rej    <= 1'b0;
      end else begin
         r_err_insuf   <= 1'b0;
         r_err_soldout <= 1'b0;
         r_coin_rej    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_p) begin
                  r_credit <= '0;
                  r_change <= '0;
                  r_state  <= ST_COINS;
               end
            end
            ST_COINS: begin
               if (cancel_p || w_timeout) begin
                  r_change <= r_credit;
                  r_credit <= '0;
                  r_state  <= ST_IDLE;
               end else if (buy_p) begin
                  if (w_buy_ok) begin
                     r_change <= r_credit - w_price;
                     r_credit <= '0;
                     r_motor  <= 1'b1;
                     r_state  <= ST_DISPENSE;
                  end else if (w_soldout) begin
                     r_err_soldout <= 1'b1;
                  end else begin
                     r_err_insuf <= 1'b1;
                  end
               end else if (coin_p) begin
                  if (w_coin_fit) begin
                     r_credit <= w_sum[CREDIT_W-1:0];
                  end else begin
                     r_coin_rej <= 1'b1;
                  end
               end
            end
            ST_DISPENSE: begin
               if (w_tmr_done) begin
                  r_motor <= 1'b0;
                  r_state <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (collected) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign credit      = r_credit;
   assign change      = r_change;
   assign motor       = r_motor;
   assign state       = r_state;
   assign err_insuf   = r_err_insuf;
   assign err_soldout = r_err_soldout;
   assign coin_rej    = r_coin_rej;

endmodule

`default_nettype wire

// File: tb/tb_vending_ctrl_multi.sv
// ============================================================================
// Module      : tb_vending_ctrl_multi
// Description : Directed scenarios plus random strobes against a cycle-level
//               behavioural model of the vending controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vending_ctrl_multi;

   localparam int NP      = 4;
   localparam int MOTOR   = 50;
   localparam int TIMEOUT = 1000;
   localparam int CMAX    = 255;
`ifdef VEND_STOCK_EN
   localparam bit STK_EN   = 1'b1;
   localparam int TB_STOCK = 1;
`else
   localparam bit STK_EN   = 1'b0;
   localparam int TB_STOCK = 3;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_p = 1'b0, coin_p = 1'b0, buy_p = 1'b0, cancel_p = 1'b0;
   logic [3:0] coin_val = '0;
   logic [1:0] sel = '0;
   logic       collected = 1'b0;
   logic [7:0] credit, change;
   logic       motor;
   logic [1:0] state;
   logic       err_insuf, err_soldout, coin_rej;

   int checks = 0;
   int errors = 0;

   int tb_price [NP] = '{7, 9, 2, 4};
   int m_state, m_credit, m_change, m_idle, m_run;
   bit m_motor, m_ins, m_sold, m_rej;
   int m_stock [NP];

   vending_ctrl_multi #(
      .STOCK_INIT (TB_STOCK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_p     (start_p),
      .coin_p      (coin_p),
      .buy_p       (buy_p),
      .cancel_p    (cancel_p),
      .coin_val    (coin_val),
      .sel         (sel),
      .collected   (collected),
      .credit      (credit),
      .change      (change),
      .motor       (motor),
      .state       (state),
      .err_insuf   (err_insuf),
      .err_soldout (err_soldout),
      .coin_rej    (coin_rej)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_credit = 0; m_change = 0; m_idle = 0; m_run = 0;
      m_motor = 0; m_ins = 0; m_sold = 0; m_rej = 0;
      for (int i = 0; i < NP; i++) m_stock[i] = TB_STOCK;
   endtask

   // One rising edge of the specified behaviour, computed from the current inputs.
   task automatic model_step();
      int price;
      bit valid;
      m_ins = 0; m_sold = 0; m_rej = 0;
      case (m_state)
         0: if (start_p) begin
               m_state = 1; m_credit = 0; m_change = 0; m_idle = 0;
            end
         1: begin
            valid = (int'(sel) < NP);
            price = valid ? tb_price[sel] : 0;
            if (cancel_p || buy_p || coin_p) m_idle = 0;
            else m_idle++;
            if (cancel_p) begin
               m_change = m_credit; m_credit = 0; m_state = 0;
            end else if (buy_p) begin
               if (valid && STK_EN && m_stock[sel] == 0) m_sold = 1;
               else if (!valid || m_credit < price) m_ins = 1;
               else begin
                  m_change = m_credit - price; m_credit = 0;
                  m_motor = 1; m_state = 2; m_run = 0;
                  if (STK_EN) m_stock[sel]--;
               end
            end else if (coin_p) begin
               if (m_credit + int'(coin_val) <= CMAX) m_credit += int'(coin_val);
               else m_rej = 1;
            end else if (m_idle == TIMEOUT) begin
               m_change = m_credit; m_credit = 0; m_state = 0;
            end
         end
         2: begin
            m_run++;
            if (m_run == MOTOR) begin
               m_motor = 0; m_state = 3;
            end
         end
         default: if (collected) m_state = 0;
      endcase
   endtask

   task automatic compare_all();
      chk("state", int'(state), m_state);
      chk("credit", int'(credit), m_credit);
      chk("change", int'(change), m_change);
      chk("motor", int'(motor), int'(m_motor));
      chk("err_insuf", int'(err_insuf), int'(m_ins));
      chk("err_soldout", int'(err_soldout), int'(m_sold));
      chk("coin_rej", int'(coin_rej), int'(m_rej));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      start_p = 0; coin_p = 0; buy_p = 0; cancel_p = 0;
   endtask

   task automatic do_start();          start_p = 1;                tick(); endtask
   task automatic do_coin(input int v); coin_p = 1; coin_val = 4'(v); tick(); endtask
   task automatic do_buy(input int s);  buy_p = 1; sel = 2'(s);      tick(); endtask
   task automatic idle(input int n);    for (int i = 0; i < n; i++) tick(); endtask

   task automatic collect();
      collected = 1; tick(); collected = 0;
   endtask

   initial begin
      int high_cnt;
      model_reset();
      #23;
      chk("rst_state", int'(state), 0);
      chk("rst_credit", int'(credit), 0);
      chk("rst_change", int'(change), 0);
      chk("rst_motor", int'(motor), 0);
      rst = 1;

      // Cheapest product, exact credit
      do_start(); do_coin(1); do_coin(1); do_buy(2);
      chk("p2_motor_on", int'(motor), 1);
      chk("p2_change", int'(change), 0);
      high_cnt = 1;
      for (int i = 0; i < MOTOR + 5; i++) begin
         tick();
         if (motor) high_cnt++;
      end
      chk("p2_motor_cycles", high_cnt, MOTOR);
      chk("p2_collect_state", int'(state), 3);
      collect();
      chk("p2_idle", int'(state), 0);

      // Overpay and change persistence in IDLE
      do_start(); do_coin(3); do_coin(3); do_buy(3);
      chk("p3_change", int'(change), 2);
      chk("p3_credit", int'(credit), 0);
      chk("p3_state", int'(state), 2);
      idle(MOTOR); collect(); idle(5);
      chk("p3_change_held", int'(change), 2);
      do_start();
      chk("p3_change_clr", int'(change), 0);

      // Insufficient credit, then inactivity refund
      do_coin(2); do_coin(2); do_buy(1);
      chk("p1_insuf", int'(err_insuf), 1);
      chk("p1_credit", int'(credit), 4);
      chk("p1_state", int'(state), 1);
      tick();
      chk("p1_insuf_gone", int'(err_insuf), 0);
      idle(TIMEOUT - 2);
      chk("to_not_yet", int'(state), 1);
      tick();
      chk("to_state", int'(state), 0);
      chk("to_change", int'(change), 4);

      // Credit ceiling and cancel-over-buy priority
      do_start();
      for (int i = 0; i < 16; i++) do_coin(15);
      do_coin(10);
      chk("ovf_credit", int'(credit), 250);
      do_coin(9);
      chk("ovf_rej", int'(coin_rej), 1);
      chk("ovf_credit_kept", int'(credit), 250);
      cancel_p = 1; do_buy(0);
      chk("cb_change", int'(change), 250);
      chk("cb_state", int'(state), 0);
      chk("cb_motor", int'(motor), 0);

`ifdef VEND_STOCK_EN
      do_start(); do_coin(1); do_coin(1); do_buy(2);
      idle(MOTOR); collect();
      do_start(); do_coin(1); do_coin(1); do_buy(2);
      chk("so_flag", int'(err_soldout), 1);
      chk("so_credit", int'(credit), 2);
      chk("so_state", int'(state), 1);
      cancel_p = 1; tick();
`endif

      // Asynchronous reset in the middle of dispensing
      do_start(); do_coin(15); do_buy(0);
      idle(10);
      chk("ar_motor_before", int'(motor), 1);
      #2 rst = 0;
      #1;
      model_reset();
      chk("ar_motor", int'(motor), 0);
      chk("ar_credit", int'(credit), 0);
      chk("ar_change", int'(change), 0);
      chk("ar_state", int'(state), 0);
      #2 rst = 1;

      // Random strobes, including same-cycle collisions
      for (int i = 0; i < 4000; i++) begin
         start_p   = ($urandom_range(0, 9) == 0);
         coin_p    = ($urandom_range(0, 2) == 0);
         coin_val  = 4'($urandom_range(0, 15));
         buy_p     = ($urandom_range(0, 11) == 0);
         cancel_p  = ($urandom_range(0, 39) == 0);
         sel       = 2'($urandom_range(0, 3));
         collected = ($urandom_range(0, 7) == 0);
         tick();
      end
      collected = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
